// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded ID state for EX, detects load-use
// hazards, handles branch flush and downstream hold, and counts bubbles/flushes.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ID_valid_i,
   input  logic [XLEN-1:0]  ID_pc_i,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic [4:0]       ID_rd_i,
   input  logic             ID_uses_rs1_i,
   input  logic             ID_uses_rs2_i,
   input  logic [XLEN-1:0]  ID_rs1_data_i,
   input  logic [XLEN-1:0]  ID_rs2_data_i,
   input  logic [XLEN-1:0]  ID_imm_i,
   input  logic [3:0]       ID_alu_op_i,
   input  logic             ID_alu_src_i,
   input  logic             ID_mem_rd_i,
   input  logic             ID_mem_wr_i,
   input  logic             ID_reg_wr_en_i,
   input  logic [1:0]       ID_wb_sel_i,
   input  logic             EX_branch_taken_i,
   input  logic             EX_stall_i,
   output logic             ID_stall_o,
   output logic             EX_valid_o,
   output logic [XLEN-1:0]  EX_pc_o,
   output logic [4:0]       EX_rs1_o,
   output logic [4:0]       EX_rs2_o,
   output logic [4:0]       EX_rd_o,
   output logic [XLEN-1:0]  EX_rs1_data_o,
   output logic [XLEN-1:0]  EX_rs2_data_o,
   output logic [XLEN-1:0]  EX_imm_o,
   output logic [3:0]       EX_alu_op_o,
   output logic             EX_alu_src_o,
   output logic             EX_mem_rd_o,
   output logic             EX_mem_wr_o,
   output logic             EX_reg_wr_en_o,
   output logic [1:0]       EX_wb_sel_o,
   output logic [CNT_W-1:0] bubble_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = ID_uses_rs1_i && (ID_rs1_i == EX_rd_o);
      rs2_hit  = ID_uses_rs2_i && (ID_rs2_i == EX_rd_o);
      // x0 is never a real producer, so rd==0 cannot create a dependency
      load_use = EX_valid_o && EX_mem_rd_o && (EX_rd_o != 5'd0) && ID_valid_i
                 && (rs1_hit || rs2_hit);
      ID_stall_o = !EX_branch_taken_i && (EX_stall_i || load_use);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         EX_valid_o     <= 1'b0;
         EX_pc_o        <= '0;
         EX_rs1_o       <= '0;
         EX_rs2_o       <= '0;
         EX_rd_o        <= '0;
         EX_rs1_data_o  <= '0;
         EX_rs2_data_o  <= '0;
         EX_imm_o       <= '0;
         EX_alu_op_o    <= '0;
         EX_alu_src_o   <= 1'b0;
         EX_mem_rd_o    <= 1'b0;
         EX_mem_wr_o    <= 1'b0;
         EX_reg_wr_en_o <= 1'b0;
         EX_wb_sel_o    <= '0;
         bubble_cnt_o   <= '0;
         flush_cnt_o    <= '0;
      end else if (EX_branch_taken_i) begin
         EX_valid_o     <= 1'b0;
         EX_mem_rd_o    <= 1'b0;
         EX_mem_wr_o    <= 1'b0;
         EX_reg_wr_en_o <= 1'b0;
         if (ID_valid_i && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + 1'b1;
      end else if (!EX_stall_i) begin
         if (load_use) begin
            // Bubble: only the side-effecting controls are cleared, data fields hold
            EX_valid_o     <= 1'b0;
            EX_mem_rd_o    <= 1'b0;
            EX_mem_wr_o    <= 1'b0;
            EX_reg_wr_en_o <= 1'b0;
            if (bubble_cnt_o != '1)
               bubble_cnt_o <= bubble_cnt_o + 1'b1;
         end else begin
            EX_valid_o     <= ID_valid_i;
            EX_pc_o        <= ID_pc_i;
            EX_rs1_o       <= ID_rs1_i;
            EX_rs2_o       <= ID_rs2_i;
            EX_rd_o        <= ID_rd_i;
            EX_rs1_data_o  <= ID_rs1_data_i;
            EX_rs2_data_o  <= ID_rs2_data_i;
            EX_imm_o       <= ID_imm_i;
            EX_alu_op_o    <= ID_alu_op_i;
            EX_alu_src_o   <= ID_alu_src_i;
            EX_mem_rd_o    <= ID_valid_i && ID_mem_rd_i;
            EX_mem_wr_o    <= ID_valid_i && ID_mem_wr_i;
            EX_reg_wr_en_o <= ID_valid_i && ID_reg_wr_en_i;
            EX_wb_sel_o    <= ID_wb_sel_i;
         end
      end
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core; sits directly downstream of the register file.
- Captures register-file read data (rs1/rs2), immediate, PC and decoded control from ID, and presents them registered to EX.
- Owns load-use hazard detection: inserts a bubble and stalls IF/ID when EX holds a load whose rd is needed by the ID instruction.
- Also handles branch flush, downstream hold, and two saturating performance counters.

Parameters:
- XLEN, 32, data/PC width
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- ID_valid_i  in  1  ID holds a real instruction
- ID_pc_i  in  XLEN  PC of ID instruction
- ID_rs1_i, ID_rs2_i, ID_rd_i  in  5 each  register indices
- ID_uses_rs1_i, ID_uses_rs2_i  in  1 each  instruction actually reads rs1/rs2
- ID_rs1_data_i, ID_rs2_data_i  in  XLEN each  register-file read data
- ID_imm_i  in  XLEN  sign-extended immediate
- ID_alu_op_i  in  4  ALU operation
- ID_alu_src_i  in  1  0=rs2, 1=imm
- ID_mem_rd_i, ID_mem_wr_i  in  1 each  load/store
- ID_reg_wr_en_i  in  1  writes rd
- ID_wb_sel_i  in  2  writeback source select
- EX_branch_taken_i  in  1  EX resolved taken branch/jump; kill ID instruction
- EX_stall_i  in  1  downstream hold (e.g. memory busy)
- ID_stall_o  out  1  hold PC and IF/ID register this cycle
- EX_valid_o, EX_pc_o, EX_rs1_o, EX_rs2_o, EX_rd_o, EX_rs1_data_o, EX_rs2_data_o, EX_imm_o, EX_alu_op_o, EX_alu_src_o, EX_mem_rd_o, EX_mem_wr_o, EX_reg_wr_en_o, EX_wb_sel_o  out  widths as ID counterparts  registered stage outputs
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted
- flush_cnt_o  out  CNT_W  valid instructions killed by flush

Behaviour:
- Reset (rst_i=1 at rising edge): every EX_* output and both counters go to 0. Reset overrides all other inputs, including mid-stall.
- load_use (combinational) = EX_valid_o & EX_mem_rd_o & (EX_rd_o!=0) & ID_valid_i & ((ID_uses_rs1_i & ID_rs1_i==EX_rd_o) | (ID_uses_rs2_i & ID_rs2_i==EX_rd_o)).
- ID_stall_o = ~EX_branch_taken_i & (EX_stall_i | load_use). Combinational, no added latency.
- Update priority per clock edge, highest first:
  1. Reset.
  2. Flush (EX_branch_taken_i=1): EX_valid_o<=0; EX_reg_wr_en_o, EX_mem_rd_o, EX_mem_wr_o <=0; other fields don't-care (hold). flush_cnt_o increments if ID_valid_i=1. Flush wins over EX_stall_i.
  3. Hold (EX_stall_i=1): all EX_* registers keep their value.
  4. Bubble (load_use=1): same clearing as flush; bubble_cnt_o increments.
  5. Load: all EX_* <= ID counterparts; EX_valid_o<=ID_valid_i. If ID_valid_i=0, the three control enables are forced to 0.
- Latency: one cycle ID->EX. A load-use pair costs exactly one bubble: the cycle after the bubble, the load has left EX, load_use drops, and the dependent instruction loads.
- x0: rd=0 never triggers load_use. Stores (mem_wr) never trigger it as producer.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- A held (stalled) bubble is not recounted: counters increment only on priority-2/4 edges.
- No forwarding is performed here. The write-before-read bypass in the register file covers the WB->ID distance.

Test Plan:
- Reset mid-operation: load valid ADD (rd=5) then assert rst_i with EX_stall_i=1 -> next cycle EX_valid_o=0, EX_rd_o=0, counters=0.
- Straight load: ID_valid_i=1, pc=0x100, rs1_data=0x11, imm=0x4, reg_wr_en=1 -> after one edge EX_pc_o=0x100, EX_rs1_data_o=0x11, EX_imm_o=0x4, EX_valid_o=1, ID_stall_o=0.
- Load-use: EX holds LW rd=7; ID has ADD rs1=7, uses_rs1=1 -> ID_stall_o=1; next edge EX_valid_o=0, bubble_cnt_o=1; following edge EX has ADD, ID_stall_o=0. Repeat with rd=0 -> no stall; with uses_rs1=0 -> no stall.
- Flush vs stall: EX_branch_taken_i=1 and EX_stall_i=1 with ID_valid_i=1 -> ID_stall_o=0; next EX_valid_o=0, EX_mem_wr_o=0, flush_cnt_o=1.
- Downstream hold: EX holds SW pc=0x200; EX_stall_i=1 for 3 cycles with changing ID inputs -> EX outputs unchanged for 3 cycles, ID_stall_o=1 throughout.
- Saturation: CNT_W=2; force 5 load-use bubbles -> bubble_cnt_o sequence 1,2,3,3,3.
